fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue sitting directly upstream of the instruction decoder. It issues word-aligned fetch requests to the instruction bus and buffers returned instruction words together with their PCs. It presents one instruction per cycle to the decode stage over a valid/acknowledge handshake, and discards in-flight fetches when the pipeline redirects on a jump.

## Interface

Parameters:
- `C_DEPTH`, default 4: queue entries and maximum outstanding fetches; power of two, ≥ 2.
- `C_RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `resetb_i` in 1: reset, synchronous, active-low.
- `jump_i` in 1: redirect request from execute; flushes the queue.
- `jump_addr_i` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `ireqvalid_o` out 1: fetch request valid.
- `ireqready_i` in 1: bus accepts the request this cycle.
- `ireqaddr_o` out 32: fetch address, word-aligned.
- `irspvalid_i` in 1: fetch response valid. Responses return in order, at most 1 per cycle, with no backpressure.
- `irspdata_i` in 32: fetched instruction word.
- `irsperr_i` in 1: bus error for this response.
- `ids_dav_o` out 1: head entry valid (data available to decode).
- `ids_ack_i` in 1: decode consumes the head entry; ignored when `ids_dav_o` = 0.
- `ids_ins_o` out 32: head instruction word; drives the decoder's `ins_i`.
- `ids_pc_o` out 32: PC of the head instruction.
- `ids_ferr_o` out 1: head entry carries a fetch error.

## Operation

State:
- `fetch_pc` (32): next request address.
- `rsp_pc` (32): PC to tag the next accepted response with.
- `inflight` (0..C_DEPTH): requests accepted by the bus and not yet answered.
- `stale` (0..inflight): in-flight requests whose responses are to be dropped.
- `count` (0..C_DEPTH): queue occupancy; circular buffer of {ins, pc, err} with read and write pointers.

Request issue:
- `ireqvalid_o` = resetb_i & !jump_i & ((inflight − stale) + count < C_DEPTH) & (inflight < C_DEPTH).
- A transfer occurs when `ireqvalid_o` & `ireqready_i`. On a transfer, `fetch_pc` += 4 and `inflight` increments.
- `ireqvalid_o` may drop without a transfer, but only when `jump_i` is asserted.

Response handling:
- Every response decrements `inflight`.
- If `stale` > 0, the response is dropped and `stale` decrements.
- Otherwise the entry {irspdata_i, rsp_pc, irsperr_i} is written at the write pointer and `rsp_pc` += 4.
- The credit rule guarantees the queue is never full on a write. A write to a full queue is a bus protocol violation; the bench asserts on it.
- Error entries are queued like normal entries. Fetching continues after an error; the decode/trap path handles the error.

Dequeue:
- `ids_ack_i` & `ids_dav_o` advances the read pointer and decrements `count`.
- Enqueue and dequeue in the same cycle leave `count` unchanged.

Jump (highest priority):
- `count` := 0; both pointers reset to 0.
- `fetch_pc` and `rsp_pc` := {jump_addr_i[31:2], 2'b00}.
- `stale` := inflight − (irspvalid_i ? 1 : 0); a response arriving in the jump cycle is dropped.
- No request is issued in the jump cycle.
- A simultaneous `ids_ack_i` is overridden.
- A jump while `stale` > 0 recomputes `stale` from `inflight`, so all older fetches are dropped.

Pointer arithmetic:
- Pointers are $clog2(C_DEPTH) bits and wrap naturally.
- `count` and `inflight` are $clog2(C_DEPTH)+1 bits.

## Timing

Reset values while `resetb_i` = 0 (at the clock edge):
- `fetch_pc` = `rsp_pc` = C_RESET_VECTOR.
- `inflight` = `stale` = `count` = 0.
- `ids_dav_o` = 0 and `ireqvalid_o` = 0; `irspvalid_i` is ignored.
- `ids_ins_o`, `ids_pc_o`, `ids_ferr_o` = 0.
- The bus is reset in the same cycle. Reset mid-operation discards all queued and in-flight state.

Cycle-level behaviour:
- First request: `ireqvalid_o` = 1 with address C_RESET_VECTOR in the first cycle after reset deasserts.
- Response latency: a response in cycle M makes `ids_dav_o` = 1 in cycle M+1 (queue previously empty). Head outputs come from registers or the storage array, never combinationally from `irsp*`.
- Redirect latency: `jump_i` in cycle N puts `ireqaddr_o` = target in cycle N+1, and `ids_dav_o` = 0 in N+1.
- Throughput: with a zero-wait bus and continuous `ids_ack_i`, the block sustains 1 request, 1 response and 1 dequeue per cycle.
- `ids_*` outputs are stable while `ids_dav_o` = 1 and `ids_ack_i` = 0.

## Test plan

- **Reset fetch:** reset, bus ready, 1-cycle response latency, decode always acks, C_RESET_VECTOR = 0x100. Expect requests 0x100, 0x104, 0x108… on consecutive cycles, and `ids_pc_o` sequence 0x100, 0x104… starting 2 cycles after the first request.
- **Backpressure fill:** `ids_ack_i` = 0, C_DEPTH = 4. Expect exactly 4 request transfers, then `ireqvalid_o` held 0. `count` = 4, head pc = 0x100 stable. One ack re-enables exactly 1 request.
- **Flush with in-flight fetches:** 3 requests outstanding (bus latency 3), jump to 0x2002. Expect the 3 old responses dropped, `ids_dav_o` = 0 until the first response for 0x2000, `ids_pc_o` = 0x2000, no request in the jump cycle.
- **Jump coincident with response and ack:** jump_i, irspvalid_i, ids_ack_i all in one cycle. Expect the response dropped, queue empty next cycle, `stale` = inflight − 1.
- **Back-to-back jumps:** jump to 0x400, then to 0x800 on the next cycle before any response returns. Expect no entry with pc 0x400 ever presented; first presented pc = 0x800.
- **Fetch error and reset mid-stream:** `irsperr_i` = 1 on the 2nd response. Expect `ids_ferr_o` = 1 only with pc 0x104 and fetching to continue. Asserting `resetb_i` = 0 for 1 cycle mid-stream gives `ids_dav_o` = 0 and a restart at C_RESET_VECTOR.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue; issues word fetches against a credit limit,
// buffers {ins, pc, err} entries for decode and drops in-flight responses after a jump.
module fetch_queue #(
    parameter int          C_DEPTH        = 4,
    parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        ireqvalid_o,
    input  logic        ireqready_i,
    output logic [31:0] ireqaddr_o,
    input  logic        irspvalid_i,
    input  logic [31:0] irspdata_i,
    input  logic        irsperr_i,
    output logic        ids_dav_o,
    input  logic        ids_ack_i,
    output logic [31:0] ids_ins_o,
    output logic [31:0] ids_pc_o,
    output logic        ids_ferr_o
);
    localparam int AW = $clog2(C_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(C_DEPTH);

    logic [31:0]   fetch_pc, rsp_pc, jump_pc;
    logic [CW-1:0] inflight, stale, count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   ins_mem [C_DEPTH];
    logic [31:0]   pc_mem  [C_DEPTH];
    logic          err_mem [C_DEPTH];
    logic [CW:0]   credit;
    logic          xfer, take, deq;

    // Live (non-stale) in-flight fetches each hold a queue slot in reserve.
    always_comb begin
        jump_pc     = jump_addr_i & ~32'd3;
        credit      = {1'b0, inflight - stale} + {1'b0, count};
        ireqvalid_o = resetb_i & ~jump_i & (credit < DEPTH) & ({1'b0, inflight} < DEPTH);
        ireqaddr_o  = fetch_pc;
        xfer        = ireqvalid_o & ireqready_i;
        take        = irspvalid_i & (stale == '0);
        ids_dav_o   = count != '0;
        deq         = ids_dav_o & ids_ack_i;
        ids_ins_o   = ids_dav_o ? ins_mem[rd_ptr] : 32'd0;
        ids_pc_o    = ids_dav_o ? pc_mem[rd_ptr] : 32'd0;
        ids_ferr_o  = ids_dav_o & err_mem[rd_ptr];
    end

    always_ff @(posedge clk_i) begin
        if (!resetb_i) begin
            fetch_pc <= C_RESET_VECTOR;
            rsp_pc   <= C_RESET_VECTOR;
            inflight <= '0;
            stale    <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (jump_i) begin
            fetch_pc <= jump_pc;
            rsp_pc   <= jump_pc;
            inflight <= inflight - CW'(irspvalid_i);
            stale    <= inflight - CW'(irspvalid_i);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (xfer) fetch_pc <= fetch_pc + 32'd4;
            inflight <= inflight + CW'(xfer) - CW'(irspvalid_i);
            if (irspvalid_i && stale != '0) stale <= stale - CW'(1);
            if (take) begin
                wr_ptr <= wr_ptr + AW'(1);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(take) - CW'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (resetb_i && !jump_i && take) begin
            ins_mem[wr_ptr] <= irspdata_i;
            pc_mem[wr_ptr]  <= rsp_pc;
            err_mem[wr_ptr] <= irsperr_i;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: per-cycle vector table for fetch/jump/error/reset behaviour,
// plus a hand-driven backpressure fill with a 1-cycle bus model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        resetb, jump, ireqvalid, ireqready, irspvalid, irsperr;
    logic        ids_dav, ids_ack, ids_ferr;
    logic [31:0] jump_addr, ireqaddr, irspdata, ids_ins, ids_pc;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fetch_queue #(.C_DEPTH(4), .C_RESET_VECTOR(32'h0000_0100)) dut (
        .clk_i(clk), .resetb_i(resetb), .jump_i(jump), .jump_addr_i(jump_addr),
        .ireqvalid_o(ireqvalid), .ireqready_i(ireqready), .ireqaddr_o(ireqaddr),
        .irspvalid_i(irspvalid), .irspdata_i(irspdata), .irsperr_i(irsperr),
        .ids_dav_o(ids_dav), .ids_ack_i(ids_ack), .ids_ins_o(ids_ins),
        .ids_pc_o(ids_pc), .ids_ferr_o(ids_ferr)
    );

    typedef struct {
        logic        rst, jmp;
        logic [31:0] ja;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        re, ack, ck, e_rv;
        logic [31:0] e_addr;
        logic        e_dav;
        logic [31:0] e_pc, e_ins;
        logic        e_err;
    } vec_t;

    function automatic vec_t v(input logic rst, jmp, input logic [31:0] ja,
                               input logic rdy, rv, input logic [31:0] rd,
                               input logic re, ack, ck, erv, input logic [31:0] ea,
                               input logic edav, input logic [31:0] epc, eins,
                               input logic eerr);
        v = '{rst, jmp, ja, rdy, rv, rd, re, ack, ck, erv, ea, edav, epc, eins, eerr};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // A response written into a full queue means the credit rule broke.
    always @(posedge clk)
        if (resetb && !jump && irspvalid && dut.stale == 0 && dut.count == 4) begin
            failures++;
            $display("FAIL full_write: response accepted with count=%0d", dut.count);
        end

    vec_t        tbl[$];
    logic        pend, xf;
    logic [31:0] paddr, xaddr;
    int          n;

    initial begin
        // rst jmp ja rdy rv rdata err ack | ck e_rv e_addr e_dav e_pc e_ins e_err
        tbl.push_back(v(0,0,0,1,1,32'hCAFE0000,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,1,0,0,0,1, 1,1,32'h100,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0100,0,1, 1,1,32'h104,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0104,1,1, 1,1,32'h108,1,32'h100,32'hCAFE0100,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0108,0,1, 1,1,32'h10C,1,32'h104,32'hCAFE0104,1));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE010C,0,1, 1,1,32'h110,1,32'h108,32'hCAFE0108,0));
        tbl.push_back(v(0,0,0,1,1,32'hCAFE0110,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,1,0,0,0,1, 1,1,32'h100,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0100,0,1, 1,1,32'h104,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0104,0,1, 1,1,32'h108,1,32'h100,32'hCAFE0100,0));
        tbl.push_back(v(1,1,32'h300,1,1,32'hCAFE0108,0,1, 1,0,0,1,32'h104,32'hCAFE0104,0));
        tbl.push_back(v(1,0,0,1,0,0,0,1, 1,1,32'h300,0,0,0,0));
        tbl.push_back(v(1,0,0,1,0,0,0,1, 1,1,32'h304,0,0,0,0));
        tbl.push_back(v(1,0,0,1,0,0,0,1, 1,1,32'h308,0,0,0,0));
        tbl.push_back(v(1,1,32'h2002,1,0,0,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0300,0,1, 1,1,32'h2000,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0304,0,1, 1,1,32'h2004,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0308,0,1, 1,1,32'h2008,0,0,0,0));
        tbl.push_back(v(1,0,0,0,1,32'hCAFE2000,0,0, 1,1,32'h200C,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0, 1,1,32'h200C,1,32'h2000,32'hCAFE2000,0));
        tbl.push_back(v(1,1,32'h400,1,1,32'hCAFE2004,0,1, 1,0,0,1,32'h2000,32'hCAFE2000,0));
        tbl.push_back(v(1,1,32'h800,1,0,0,0,1, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE2008,0,1, 1,1,32'h800,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0800,0,1, 1,1,32'h804,0,0,0,0));
        tbl.push_back(v(1,0,0,1,1,32'hCAFE0804,0,1, 1,1,32'h808,1,32'h800,32'hCAFE0800,0));
        tbl.push_back(v(1,0,0,0,0,0,0,1, 1,1,32'h80C,1,32'h804,32'hCAFE0804,0));
        tbl.push_back(v(1,0,0,0,1,32'hCAFE0808,0,1, 1,1,32'h80C,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0, 1,1,32'h80C,1,32'h808,32'hCAFE0808,0));

        resetb = 0; jump = 0; jump_addr = 0; ireqready = 1;
        irspvalid = 0; irspdata = 0; irsperr = 0; ids_ack = 0;
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            resetb = tbl[i].rst; jump = tbl[i].jmp; jump_addr = tbl[i].ja;
            ireqready = tbl[i].rdy; irspvalid = tbl[i].rv; irspdata = tbl[i].rd;
            irsperr = tbl[i].re; ids_ack = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("c%0d_reqvalid", i), 32'(ireqvalid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("c%0d_reqaddr", i), ireqaddr, tbl[i].e_addr);
            if (tbl[i].ck) chk($sformatf("c%0d_dav", i), 32'(ids_dav), 32'(tbl[i].e_dav));
            if (tbl[i].ck && tbl[i].e_dav) begin
                chk($sformatf("c%0d_pc", i), ids_pc, tbl[i].e_pc);
                chk($sformatf("c%0d_ins", i), ids_ins, tbl[i].e_ins);
                chk($sformatf("c%0d_ferr", i), 32'(ids_ferr), 32'(tbl[i].e_err));
            end
            @(posedge clk); #1;
        end

        // Backpressure fill: no acks, 1-cycle bus, exactly C_DEPTH fetches then hold.
        resetb = 0; jump = 0; ireqready = 1; irspvalid = 0; irsperr = 0; ids_ack = 0;
        @(posedge clk); #1;
        resetb = 1; pend = 0; paddr = 0; n = 0;
        for (int i = 0; i < 10; i++) begin
            irspvalid = pend; irspdata = {16'hCAFE, paddr[15:0]};
            @(negedge clk);
            if (i >= 5) begin
                chk("bp_dav", 32'(ids_dav), 32'd1);
                chk("bp_head_pc", ids_pc, 32'h100);
            end
            xf = ireqvalid & ireqready;
            if (xf) n++;
            pend = xf; paddr = ireqaddr;
            @(posedge clk); #1;
        end
        chk("bp_req_count", 32'(n), 32'd4);
        chk("bp_hold", 32'(ireqvalid), 32'd0);

        n = 0; xaddr = 0;
        for (int i = 0; i < 6; i++) begin
            ids_ack = (i == 0);
            irspvalid = pend; irspdata = {16'hCAFE, paddr[15:0]};
            @(negedge clk);
            xf = ireqvalid & ireqready;
            if (xf) begin n++; xaddr = ireqaddr; end
            pend = xf; paddr = ireqaddr;
            @(posedge clk); #1;
        end
        ids_ack = 0;
        chk("bp_one_more_req", 32'(n), 32'd1);
        chk("bp_one_more_addr", xaddr, 32'h110);
        chk("bp_new_head_pc", ids_pc, 32'h104);
        chk("bp_hold_again", 32'(ireqvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
